rot_unit_arbiter: RTL and testbench
===================================

# rot_unit_arbiter

Shared controller for the 4-bit rotate unit of the CPU datapath. Arbitrates between two requesters (port 0: execute stage, port 1: indirect-load address path) with round-robin priority. Sequences each accepted rotate (ROL/ROR by 0..WIDTH-1) through a 1-bit-per-cycle step engine. Returns the result over a valid/ready response channel tagged with the requester ID.

## Interface
- WIDTH, 4: data width; a power of 2, at least 2.
- AMT_W, 2: rotate-amount width; must equal log2(WIDTH).

- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 has an operation pending.
- req0_ready  out  1  port 0 operation is accepted this cycle.
- req0_a  in  WIDTH  port 0 operand.
- req0_amt  in  AMT_W  port 0 rotate amount.
- req0_dir  in  1  port 0 direction: 0 = ROL, 1 = ROR.
- req1_valid, req1_ready, req1_a, req1_amt, req1_dir: same as port 0, for port 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_r  out  WIDTH  rotated result.
- rsp_id  out  1  ID of the requester that issued the operation.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ROT, RESP.
- **IDLE:**
  - Grant goes to the only valid port. If both ports are valid, grant goes to the port selected by the priority pointer (prio). If neither port is valid, there is no grant.
  - reqN_ready = (state==IDLE) & grant==N. Ready is combinational and is never high for both ports.
  - On a handshake, latch a, amt, dir and id into working registers.
  - Next state is ROT if amt != 0, otherwise RESP.
  - Set prio to the other port (the granted port becomes lowest priority).
- **ROT:**
  - Each cycle, rotate the working register by 1 position:
    - ROL: {r[W-2:0], r[W-1]}
    - ROR: {r[0], r[W-1:1]}
  - Decrement count each cycle. When count==1, the next state is RESP.
- **RESP:**
  - rsp_valid=1. rsp_r and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that handshake the next state is IDLE.
  - A new request is never accepted in the same cycle as a response handshake (one-cycle bubble).
- Result equivalence: ROL by n gives A[W-1-n:0] concatenated with A[W-1:W-n]. ROR by n equals ROL by W-n. Amount 0 passes A unchanged.
- Requesters must hold their a/amt/dir inputs stable while valid is high and ready is low. Inputs are ignored outside the handshake cycle.
- **Reset values** (asynchronous, immediate): state=IDLE, prio=0 (port 0 first), rsp_valid=0, rsp_r=0, rsp_id=0, busy=0, both ready outputs 0.
- **Reset mid-operation:** the in-flight operation is discarded. No response is produced for it.

## Timing
- Acceptance at rising edge k (IDLE, valid & ready).
- Step mode: busy is high from edge k. State is RESP after edge k+amt, so rsp_valid is first sampled high at edge k+amt+1.
- Best-case latency from acceptance to response: 1 cycle (amt=0). Worst case: WIDTH cycles (amt=WIDTH-1).
- Back-to-back throughput: one operation per amt+2 cycles when rsp_ready is held high.
- The rsp_valid and rsp_r/rsp_id outputs are registered. reqN_ready is combinational from state, prio and both valid inputs.

## Configuration
- ROT_ARB_FASTPATH_EN:
  - Defined: no ROT state. The full rotate by amt is computed combinationally at acceptance and registered. The FSM goes IDLE→RESP for every amt, giving a fixed latency: rsp_valid is sampled high at edge k+1. Throughput is one operation per 2 cycles.
  - Undefined: stepwise engine as described under Operation.
  - Results, arbitration, handshakes and reset behaviour are identical in both builds.

## Test plan
- **Single ROL:** req0 A=4'b1001, amt=1, dir=0, accepted at edge k, rsp_ready=1 → rsp_r=4'b0011, rsp_id=0. rsp_valid sampled high at edge k+2 (k+1 with FASTPATH). busy drops after the response handshake.
- **Max ROR:** req1 A=4'b1000, amt=3, dir=1 → rsp_r=4'b0001, rsp_id=1. Exactly 3 ROT cycles; rsp_valid sampled at edge k+4.
- **Fairness:** both ports valid continuously from reset release; port 0 sends A=4'h1, port 1 sends A=4'h2, amt=0 → grant order 0,1,0,1 over 4 operations, and each rsp_id matches the grant.
- **Backpressure:** rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_r and rsp_id stay constant. Both ready outputs stay 0 and busy=1. Release → IDLE on the next edge.
- **Reset mid-ROT:** rst_n pulled low during amt=3 ROL → all outputs 0 with no clock edge. After release, with both ports valid, port 0 is granted first, and the aborted operation never produces a response.
- **Zero amount:** req0 A=4'b0110, amt=0, dir=1 → rsp_r=4'b0110 with 1-cycle latency in both builds.

Source files
------------

// File: rtl/rot_unit_arbiter.sv
// Round-robin arbiter and rotate sequencer for the shared rotate unit (two requesters, valid/ready response).
// Optional build macro ROT_ARB_FASTPATH_EN: full rotate computed at acceptance, no ROT state.
module rot_unit_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic             gnt_vld_c;
  logic             gnt_id_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [AMT_W-1:0] sel_amt_c;
  logic             sel_dir_c;

  // Grant the sole valid port, or the prio port when both are valid
  always_comb begin : arb
    gnt_vld_c = req0_valid | req1_valid;
    gnt_id_c  = (req0_valid & req1_valid) ? prio_q : req1_valid;
    sel_a_c   = gnt_id_c ? req1_a   : req0_a;
    sel_amt_c = gnt_id_c ? req1_amt : req0_amt;
    sel_dir_c = gnt_id_c ? req1_dir : req0_dir;
  end

  assign req0_ready = rst_n & (state_q == S_IDLE) & gnt_vld_c & ~gnt_id_c;
  assign req1_ready = rst_n & (state_q == S_IDLE) & gnt_vld_c &  gnt_id_c;

`ifdef ROT_ARB_FASTPATH_EN
  // ROR by n is ROL by (WIDTH - n) mod WIDTH, which is -n in AMT_W bits
  function automatic logic [WIDTH-1:0] rot_full(input logic [WIDTH-1:0] a,
                                                input logic [AMT_W-1:0] amt,
                                                input logic             dir);
    logic [AMT_W-1:0]   n;
    logic [2*WIDTH-1:0] dbl;
    n   = dir ? (AMT_W'(0) - amt) : amt;
    dbl = {a, a} << n;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  always_comb begin : next_state
    state_d = state_q;
    prio_d  = prio_q;
    work_d  = work_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld_c) begin
          id_d    = gnt_id_c;
          prio_d  = ~gnt_id_c;
          work_d  = rot_full(sel_a_c, sel_amt_c, sel_dir_c);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end
`else
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  always_comb begin : next_state
    state_d = state_q;
    prio_d  = prio_q;
    work_d  = work_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld_c) begin
          id_d    = gnt_id_c;
          prio_d  = ~gnt_id_c;
          work_d  = sel_a_c;
          cnt_d   = sel_amt_c;
          dir_d   = sel_dir_c;
          state_d = (sel_amt_c != AMT_W'(0)) ? S_ROT : S_RESP;
        end
      end
      S_ROT: begin
        work_d = dir_q ? {work_q[0], work_q[WIDTH-1:1]}
                       : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // Step-engine working state
  always_ff @(posedge clk or negedge rst_n) begin : step_regs
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      work_q      <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      work_q      <= work_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = work_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rot_unit_arbiter.sv
// Self-checking bench for rot_unit_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_rot_unit_arbiter;
  localparam int unsigned W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_dir;
  logic [3:0] req0_a;
  logic [1:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [3:0] req1_a;
  logic [1:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rot_unit_arbiter #(.WIDTH(4), .AMT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .rsp_id(rsp_id), .busy(busy)
  );

  // Rotate by arithmetic: ROL n = (a<<n | a>>(W-n)) mod 2^W; ROR n = ROL (W-n)
  function automatic logic [3:0] ref_rot(input logic [3:0] a, input int amt, input bit dir);
    int n;
    int v;
    n = dir ? (int'(W) - amt) % int'(W) : amt;
    v = ((int'(a) << n) | (int'(a) >> (int'(W) - n))) & 15;
    return 4'(v);
  endfunction

  // Edges between acceptance and first observation of rsp_valid
  function automatic int exp_wait(input int amt);
`ifdef ROT_ARB_FASTPATH_EN
    return 0 * amt;
`else
    return amt;
`endif
  endfunction

  task automatic idle_inputs;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic issue(input bit port, input logic [3:0] a, input logic [1:0] amt,
                       input bit dir, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (port) begin req1_valid = 1'b1; req1_a = a; req1_amt = amt; req1_dir = dir; end
    else      begin req0_valid = 1'b1; req0_a = a; req0_amt = amt; req0_dir = dir; end
    for (int i = 0; i < 50; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int w, output bit ok);
    w = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin ok = 1'b1; break; end
      w++;
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_r, rsp_id, busy, req0_ready, req1_ready} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 000000000",
                      {rsp_valid, rsp_r, rsp_id, busy, req0_ready, req1_ready});
    end
    req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 4'h0; req1_a = 4'h0;
    req0_amt = 2'd0; req1_amt = 2'd0; req0_dir = 1'b0; req1_dir = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_first_grant: got %b want 10", {req0_ready, req1_ready});
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_single_rol;
    bit ok; int w;
    issue(1'b0, 4'b1001, 2'd1, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_rol_accept: got ready=0 want 1"); end
    wait_rsp(w, ok);
    total++;
    if (!ok || w != exp_wait(1)) begin
      bad++; $display("FAIL single_rol_latency: got %0d (seen=%0d) want %0d", w, ok, exp_wait(1));
    end
    total++;
    if (rsp_r !== 4'b0011 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL single_rol_result: got r=%b id=%b want r=0011 id=0", rsp_r, rsp_id);
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_rol_done: got busy=%b valid=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_max_ror;
    bit ok; int w;
    issue(1'b1, 4'b1000, 2'd3, 1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL max_ror_accept: got ready=0 want 1"); end
    wait_rsp(w, ok);
    total++;
    if (!ok || w != exp_wait(3)) begin
      bad++; $display("FAIL max_ror_latency: got %0d want %0d", w, exp_wait(3));
    end
    total++;
    if (rsp_r !== 4'b0001 || rsp_id !== 1'b1) begin
      bad++; $display("FAIL max_ror_result: got r=%b id=%b want r=0001 id=1", rsp_r, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_amt;
    bit ok; int w;
    issue(1'b0, 4'b0110, 2'd0, 1'b1, ok);
    wait_rsp(w, ok);
    total++;
    if (!ok || w != 0) begin bad++; $display("FAIL zero_amt_latency: got %0d want 0", w); end
    total++;
    if (rsp_r !== 4'b0110 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL zero_amt_result: got r=%b id=%b want r=0110 id=0", rsp_r, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness;
    int n;
    @(negedge clk); rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h1; req0_amt = 2'd0; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_a = 4'h2; req1_amt = 2'd0; req1_dir = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      #1;
      total++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        bad++; $display("FAIL fair_both_ready: got 11 want not both");
      end
      if (rsp_valid === 1'b1) begin
        total++;
        if (rsp_id !== 1'(n % 2) || rsp_r !== ((n % 2) ? 4'h2 : 4'h1)) begin
          bad++; $display("FAIL fair_order[%0d]: got id=%b r=%h want id=%0d", n, rsp_id, rsp_r, n % 2);
        end
        n++;
        if (n == 4) idle_inputs();
      end
      @(negedge clk);
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL fair_count: got %0d want 4", n); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok; int w; logic [3:0] a; logic [1:0] amt; bit dir; logic [3:0] exp_r;
    a = 4'($urandom); amt = 2'($urandom); dir = 1'($urandom);
    exp_r = ref_rot(a, int'(amt), dir);
    rsp_ready = 1'b0;
    issue(1'b1, a, amt, dir, ok);
    wait_rsp(w, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_no_rsp: got valid=0 want 1"); end
    req0_valid = 1'b1; req0_a = 4'hF; req0_amt = 2'd0; req0_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_r !== exp_r || rsp_id !== 1'b1 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b r=%h id=%b busy=%b rdy=%b%b want v=1 r=%h id=1 busy=1 rdy=00",
                        i, rsp_valid, rsp_r, rsp_id, busy, req0_ready, req1_ready, exp_r);
      end
    end
    req0_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid_rot;
    bit ok; int n; bit acc0, acc1;
    rsp_ready = 1'b0;
    issue(1'b0, 4'b1001, 2'd3, 1'b0, ok);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_r, rsp_id, busy, req0_ready, req1_ready} !== 9'd0) begin
      bad++; $display("FAIL midrst_outputs: got %b want 000000000",
                      {rsp_valid, rsp_r, rsp_id, busy, req0_ready, req1_ready});
    end
    req0_valid = 1'b1; req0_a = 4'h5; req0_amt = 2'd0; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_a = 4'h6; req1_amt = 2'd0; req1_dir = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    n = 0; acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      #1;
      if (req0_ready === 1'b1) acc0 = 1'b1;
      if (req1_ready === 1'b1) acc1 = 1'b1;
      if (rsp_valid === 1'b1) begin
        total++;
        if (rsp_id !== 1'(n) || rsp_r !== (n == 1 ? 4'h6 : 4'h5)) begin
          bad++; $display("FAIL midrst_rsp[%0d]: got id=%b r=%h want id=%0d r=%h",
                          n, rsp_id, rsp_r, n, (n == 1 ? 4'h6 : 4'h5));
        end
        n++;
      end
      @(negedge clk);
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL midrst_count: got %0d want 2", n); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random;
    bit pv[2]; logic [3:0] pa[2]; logic [1:0] pm[2]; bit pd[2];
    bit in_flight, seen, abort, exp_id;
    int w, exp_w, done, prio, gnt;
    logic [3:0] exp_r;
    @(negedge clk); rst_n = 1'b0; idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    prio = 0; in_flight = 1'b0; seen = 1'b0; abort = 1'b0; done = 0; w = 0;
    exp_w = 0; exp_r = 4'h0; exp_id = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int cyc = 0; cyc < 3000 && done < 60 && !abort; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0) begin
          pv[p] = 1'b1; pa[p] = 4'($urandom); pm[p] = 2'($urandom); pd[p] = 1'($urandom);
        end
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_amt = pm[0]; req0_dir = pd[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_amt = pm[1]; req1_dir = pd[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!in_flight && (pv[0] || pv[1])) gnt = (pv[0] && pv[1]) ? prio : (pv[1] ? 1 : 0);
      else gnt = -1;
      total++;
      if (req0_ready !== (gnt == 0) || req1_ready !== (gnt == 1)) begin
        bad++; $display("FAIL rnd_grant: got rdy=%b%b want grant=%0d", req0_ready, req1_ready, gnt);
      end
      total++;
      if (busy !== in_flight) begin
        bad++; $display("FAIL rnd_busy: got %b want %b", busy, in_flight);
      end
      if (in_flight) begin
        if (!seen) begin
          if (rsp_valid === 1'b1) begin
            seen = 1'b1;
            total++;
            if (w != exp_w) begin bad++; $display("FAIL rnd_latency: got %0d want %0d", w, exp_w); end
          end else begin
            w++;
            if (w > 8) begin
              total++; bad++; abort = 1'b1;
              $display("FAIL rnd_timeout: got no rsp after %0d cycles want %0d", w, exp_w);
            end
          end
        end
        if (seen) begin
          total++;
          if (rsp_r !== exp_r || rsp_id !== exp_id) begin
            bad++; $display("FAIL rnd_result: got r=%h id=%b want r=%h id=%b", rsp_r, rsp_id, exp_r, exp_id);
          end
          if (rsp_ready) begin in_flight = 1'b0; done++; end
        end
      end else begin
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_spurious: got valid=%b want 0", rsp_valid); end
      end
      if (gnt >= 0) begin
        in_flight = 1'b1; seen = 1'b0; w = 0;
        exp_r = ref_rot(pa[gnt], int'(pm[gnt]), pd[gnt]);
        exp_id = 1'(gnt); exp_w = exp_wait(int'(pm[gnt]));
        pv[gnt] = 1'b0; prio = 1 - gnt;
      end
    end
    idle_inputs();
    total++;
    if (done < 60) begin bad++; $display("FAIL rnd_count: got %0d want 60", done); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_rol();
    test_max_ror();
    test_zero_amt();
    test_fairness();
    test_backpressure();
    test_reset_mid_rot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
